rv4028_sram_bridge: RTL and testbench

Bus target on the RV4028 external bus that serves 16-bit memory transactions from an 8-bit asynchronous SRAM. It sits directly downstream of the CPU bus pins, consuming `req_n`/`rd_n`/`wr_n`/`msk_n`/`iorq_n`/`addr`/`data` and generating `wait_n`. Each halfword access is split into up to two byte cycles on the SRAM, with configurable wait states.

---
 rtl/rv4028_sram_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_rv4028_sram_bridge.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv4028_sram_bridge.sv
// RV4028 bus target that serves 16-bit accesses from an 8-bit asynchronous SRAM,
// one or two byte cycles per access. Optional one-entry read buffer: RV4028_SRAM_READ_CACHE_EN.
module rv4028_sram_bridge #(
  parameter int          ADDR_BITS   = 19,
  parameter int          WAIT_STATES = 1,
  parameter logic [7:0]  BASE        = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          bus_addr,
  input  logic                 bus_req_n,
  input  logic                 bus_rd_n,
  input  logic                 bus_wr_n,
  input  logic [1:0]           bus_msk_n,
  input  logic                 bus_iorq_n,
  output logic                 bus_wait_n,
  input  logic [15:0]          bus_data_in,
  output logic [15:0]          bus_data_out,
  output logic                 bus_data_oe,
  output logic [ADDR_BITS-1:0] sram_addr,
  input  logic [7:0]           sram_dq_in,
  output logic [7:0]           sram_dq_out,
  output logic                 sram_dq_oe,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  localparam logic [2:0] WS_LAST = 3'(WAIT_STATES);

  state_t                 state_q, state_d;
  logic                   phase_q, phase_d;
  logic [ADDR_BITS-2:0]   addr_q, addr_d;
  logic                   rd_q, rd_d;
  logic [1:0]             msk_q, msk_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [15:0]            rdata_q, rdata_d;
  logic [ADDR_BITS-1:0]   sram_addr_q, sram_addr_d;
  logic [7:0]             dq_out_q, dq_out_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
`ifdef RV4028_SRAM_READ_CACHE_EN
  logic                   cvalid_q, cvalid_d;
  logic [ADDR_BITS-2:0]   ctag_q, ctag_d;
`endif

  logic                   sel;
  logic                   cache_hit;
  logic                   more;
  logic [ADDR_BITS-2:0]   req_tag;
  logic                   unused_addr_bits;

  assign req_tag          = bus_addr[ADDR_BITS-1:1];
  assign unused_addr_bits = ^{bus_addr[23:ADDR_BITS], bus_addr[0]};
  assign sel = !bus_req_n && bus_iorq_n && (bus_addr[31:24] == BASE) && (bus_rd_n != bus_wr_n);

`ifdef RV4028_SRAM_READ_CACHE_EN
  assign cache_hit = cvalid_q && (ctag_q == req_tag);
`else
  assign cache_hit = 1'b0;
`endif

  // Wait is combinational so the CPU stalls in the very cycle the request appears.
  assign bus_wait_n   = rst || !((state_q == IDLE && sel) || state_q == SETUP || state_q == STROBE);
  assign bus_data_oe  = (state_q == DONE) && rd_q && !bus_rd_n;
  assign bus_data_out = rdata_q;
  assign sram_addr    = sram_addr_q;
  assign sram_dq_out  = dq_out_q;
  assign sram_dq_oe   = dq_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    msk_d       = msk_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    more        = 1'b0;
`ifdef RV4028_SRAM_READ_CACHE_EN
    cvalid_d    = cvalid_q;
    ctag_d      = ctag_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel) begin
          addr_d  = req_tag;
          rd_d    = !bus_rd_n;
          msk_d   = bus_msk_n;
          wdata_d = bus_data_in;
          cnt_d   = 3'd0;
          if (!bus_rd_n) begin
            if (cache_hit) begin
              state_d = DONE;
            end else begin
              phase_d     = 1'b0;
              state_d     = SETUP;
              ce_n_d      = 1'b0;
              sram_addr_d = {req_tag, 1'b0};
              dq_oe_d     = 1'b0;
            end
          end else begin
`ifdef RV4028_SRAM_READ_CACHE_EN
            if (ctag_q == req_tag) cvalid_d = 1'b0;
`endif
            if (bus_msk_n == 2'b11) begin
              state_d = DONE;
            end else begin
              // First byte is the low one unless it is masked off.
              phase_d     = bus_msk_n[0];
              state_d     = SETUP;
              ce_n_d      = 1'b0;
              sram_addr_d = {req_tag, bus_msk_n[0]};
              dq_oe_d     = 1'b1;
              dq_out_d    = bus_msk_n[0] ? bus_data_in[15:8] : bus_data_in[7:0];
            end
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = 3'd0;
        if (rd_q) oe_n_d = 1'b0;
        else      we_n_d = 1'b0;
      end
      STROBE: begin
        if (cnt_q == WS_LAST) begin
          if (rd_q) begin
            if (phase_q) rdata_d[15:8] = sram_dq_in;
            else         rdata_d[7:0]  = sram_dq_in;
          end
          more   = !phase_q && (rd_q || !msk_q[1]);
          oe_n_d = 1'b1;
          we_n_d = 1'b1;
          if (more) begin
            phase_d     = 1'b1;
            state_d     = SETUP;
            sram_addr_d = {addr_q, 1'b1};
            dq_out_d    = wdata_q[15:8];
          end else begin
            state_d = DONE;
            ce_n_d  = 1'b1;
            dq_oe_d = 1'b0;
`ifdef RV4028_SRAM_READ_CACHE_EN
            if (rd_q) begin
              cvalid_d = 1'b1;
              ctag_d   = addr_q;
            end
`endif
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        if (bus_req_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      msk_q       <= 2'b11;
      wdata_q     <= 16'h0000;
      cnt_q       <= 3'd0;
      rdata_q     <= 16'h0000;
      sram_addr_q <= '0;
      dq_out_q    <= 8'h00;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
`ifdef RV4028_SRAM_READ_CACHE_EN
      cvalid_q    <= 1'b0;
      ctag_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      msk_q       <= msk_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
`ifdef RV4028_SRAM_READ_CACHE_EN
      cvalid_q    <= cvalid_d;
      ctag_q      <= ctag_d;
`endif
    end
  end

endmodule

// File: tb/tb_rv4028_sram_bridge.sv
// Self-checking bench for rv4028_sram_bridge: behavioural SRAM, reference memory/latency model,
// directed scenarios plus randomized traffic.
module tb_rv4028_sram_bridge;

  localparam int AB = 19;
  localparam int WS = 1;

  logic          clk, rst;
  logic [31:0]   bus_addr;
  logic          bus_req_n, bus_rd_n, bus_wr_n, bus_iorq_n;
  logic [1:0]    bus_msk_n;
  logic          bus_wait_n;
  logic [15:0]   bus_data_in, bus_data_out;
  logic          bus_data_oe;
  logic [AB-1:0] sram_addr;
  logic [7:0]    sram_dq_in, sram_dq_out;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  rv4028_sram_bridge #(.ADDR_BITS(AB), .WAIT_STATES(WS), .BASE(8'h00)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_req_n(bus_req_n), .bus_rd_n(bus_rd_n),
    .bus_wr_n(bus_wr_n), .bus_msk_n(bus_msk_n), .bus_iorq_n(bus_iorq_n), .bus_wait_n(bus_wait_n),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM environment ----------------
  logic [7:0]  mem [0:(1<<AB)-1];
  logic [7:0]  ref_mem [0:8191];
  logic [26:0] obs_q[$];
  logic [26:0] exp_q[$];
  logic        tr_we[$];
  logic        tr_ce[$];
  logic        we_prev = 1'b1;
  int          ce_falls = 0;

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'h00;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr] = sram_dq_out;
      if (we_prev) obs_q.push_back({sram_addr, sram_dq_out});
    end
    we_prev = sram_we_n;
  end

  always @(negedge sram_ce_n) ce_falls = ce_falls + 1;

  always @(negedge clk) begin
    tr_we.push_back(sram_we_n);
    tr_ce.push_back(sram_ce_n);
  end

  // ---------------- reference model state ----------------
  typedef struct {
    int          lat;
    int          falls;
    logic [15:0] rdata;
    logic        doe;
    int          nw;
    logic [53:0] w;
  } res_t;

  bit          c_valid = 1'b0;
  logic [17:0] c_tag = '0;
  int          n_checks = 0;
  int          n_fails  = 0;

  // Driver + model: computes expectations from the access rules, runs one bus access.
  task automatic exec(input bit is_rd, input logic [31:0] a, input logic [15:0] d,
                      input logic [1:0] m, input bit scr, output res_t got, output res_t exp);
    logic [17:0] hw;
    int          nb;
    bit          hit;
    hw  = a[18:1];
    hit = 1'b0;
    exp_q.delete();
    obs_q.delete();
    exp.rdata = 16'h0000;
    if (is_rd) begin
`ifdef RV4028_SRAM_READ_CACHE_EN
      hit     = c_valid && (c_tag == hw);
      c_valid = 1'b1;
      c_tag   = hw;
`endif
      exp.lat   = hit ? 1 : 2 * (WS + 2) + 1;
      exp.falls = hit ? 0 : 1;
      exp.rdata = {ref_mem[int'(hw) * 2 + 1], ref_mem[int'(hw) * 2]};
      exp.doe   = 1'b1;
    end else begin
      nb = 0;
      for (int b = 0; b < 2; b++) begin
        if (!m[b]) begin
          exp_q.push_back({hw, b[0], d[8*b +: 8]});
          ref_mem[int'(hw) * 2 + b] = d[8*b +: 8];
          nb++;
        end
      end
      exp.lat   = (nb == 0) ? 1 : nb * (WS + 2) + 1;
      exp.falls = (nb == 0) ? 0 : 1;
      exp.doe   = 1'b0;
      if (c_tag == hw) c_valid = 1'b0;
    end
    exp.nw = exp_q.size();
    exp.w  = '0;
    for (int i = 0; i < exp_q.size() && i < 2; i++) exp.w[27*i +: 27] = exp_q[i];

    @(posedge clk);
    #1;
    ce_falls    = 0;
    tr_we.delete();
    tr_ce.delete();
    bus_addr    = a;
    bus_data_in = d;
    bus_msk_n   = m;
    bus_iorq_n  = 1'b1;
    bus_rd_n    = !is_rd;
    bus_wr_n    = is_rd;
    bus_req_n   = 1'b0;
    got.lat     = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus_wait_n) break;
      got.lat++;
      if (scr && got.lat > 1) begin
        bus_addr[15:0] = 16'($urandom);
        bus_data_in    = 16'($urandom);
      end
    end
    got.rdata = bus_data_out;
    got.doe   = bus_data_oe;
    got.falls = ce_falls;
    @(posedge clk);
    #1;
    bus_req_n = 1'b1;
    bus_rd_n  = 1'b1;
    bus_wr_n  = 1'b1;
    @(posedge clk);
    got.nw = obs_q.size();
    got.w  = '0;
    for (int i = 0; i < obs_q.size() && i < 2; i++) got.w[27*i +: 27] = obs_q[i];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, bus_data_oe, bus_wait_n} !== 6'b111001) begin
      n_fails++;
      $display("FAIL reset_ctrl: got %b expected 111001",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, bus_data_oe, bus_wait_n});
    end
    n_checks++;
    if ({sram_addr, sram_dq_out, bus_data_out} !== '0) begin
      n_fails++;
      $display("FAIL reset_data: addr %h dq %h data_out %h expected all zero",
               sram_addr, sram_dq_out, bus_data_out);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    @(posedge clk);
    #1;
    bus_addr = 32'h0000_0040; bus_data_in = 16'h1111; bus_msk_n = 2'b00;
    bus_wr_n = 1'b0; bus_req_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    n_checks++;
    if (sram_we_n !== 1'b0) begin
      n_fails++;
      $display("FAIL strobe_before_reset: we_n got %b expected 0", sram_we_n);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({sram_we_n, sram_ce_n, bus_wait_n, sram_dq_oe} !== 4'b1110) begin
      n_fails++;
      $display("FAIL async_reset: we/ce/wait/dq_oe got %b expected 1110",
               {sram_we_n, sram_ce_n, bus_wait_n, sram_dq_oe});
    end
    bus_req_n = 1'b1; bus_wr_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    c_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus_wait_n, sram_ce_n} !== 2'b11) begin
      n_fails++;
      $display("FAIL idle_after_reset: wait/ce got %b expected 11", {bus_wait_n, sram_ce_n});
    end
    obs_q.delete();
  endtask

  task automatic test_write_bytes();
    res_t got, exp;
    int   bad;
    logic exp_we[$];
    logic exp_ce[$];
    exec(1'b0, 32'h0000_1234, 16'hBEEF, 2'b00, 1'b1, got, exp);
    n_checks++;
    if (got.lat !== 7) begin
      n_fails++; $display("FAIL wr2_latency: got %0d expected 7", got.lat);
    end
    n_checks++;
    if (got.nw !== 2 || got.w !== {19'h01235, 8'hBE, 19'h01234, 8'hEF}) begin
      n_fails++; $display("FAIL wr2_bytes: got n=%0d %h expected n=2 %h", got.nw, got.w,
                          {19'h01235, 8'hBE, 19'h01234, 8'hEF});
    end
    n_checks++;
    if (got.doe !== 1'b0) begin
      n_fails++; $display("FAIL wr2_data_oe: got %b expected 0", got.doe);
    end
    exp_we.push_back(1'b1); exp_ce.push_back(1'b1);
    for (int b = 0; b < 2; b++) begin
      exp_we.push_back(1'b1); exp_ce.push_back(1'b0);
      for (int s = 0; s <= WS; s++) begin exp_we.push_back(1'b0); exp_ce.push_back(1'b0); end
    end
    exp_we.push_back(1'b1); exp_ce.push_back(1'b1);
    bad = 0;
    for (int i = 0; i < exp_we.size(); i++) begin
      if (i >= tr_we.size()) bad++;
      else if (tr_we[i] !== exp_we[i] || tr_ce[i] !== exp_ce[i]) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++; $display("FAIL wr2_strobe_trace: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_partial_write();
    res_t got, exp;
    exec(1'b0, 32'h0000_0010, 16'hA55A, 2'b01, 1'b0, got, exp);
    n_checks++;
    if (got.lat !== exp.lat || got.falls !== exp.falls) begin
      n_fails++; $display("FAIL wr1_timing: got lat %0d falls %0d expected lat %0d falls %0d",
                          got.lat, got.falls, exp.lat, exp.falls);
    end
    n_checks++;
    if (got.nw !== 1 || got.w[26:0] !== {19'h00011, 8'hA5}) begin
      n_fails++; $display("FAIL wr1_bytes: got n=%0d %h expected n=1 %h", got.nw, got.w[26:0],
                          {19'h00011, 8'hA5});
    end
    exec(1'b0, 32'h0000_0010, 16'h1234, 2'b11, 1'b0, got, exp);
    n_checks++;
    if (got.lat !== 1 || got.falls !== 0 || got.nw !== 0) begin
      n_fails++; $display("FAIL wr0_masked: got lat %0d falls %0d writes %0d expected 1 0 0",
                          got.lat, got.falls, got.nw);
    end
  endtask

  task automatic test_read();
    res_t got, exp;
    mem[32'h20] = 8'h34; ref_mem[32'h20] = 8'h34;
    mem[32'h21] = 8'h12; ref_mem[32'h21] = 8'h12;
    exec(1'b1, 32'h0000_0020, 16'h0000, 2'b00, 1'b1, got, exp);
    n_checks++;
    if (got.rdata !== 16'h1234 || got.doe !== 1'b1) begin
      n_fails++; $display("FAIL rd_data: got %h oe %b expected 1234 oe 1", got.rdata, got.doe);
    end
    n_checks++;
    if (got.lat !== 2 * (WS + 2) + 1 || got.falls !== 1) begin
      n_fails++; $display("FAIL rd_timing: got lat %0d falls %0d expected lat %0d falls 1",
                          got.lat, got.falls, 2 * (WS + 2) + 1);
    end
    n_checks++;
    if (got.nw !== 0) begin
      n_fails++; $display("FAIL rd_no_write: got %0d writes expected 0", got.nw);
    end
  endtask

  task automatic test_cache();
    res_t got, exp;
    exec(1'b1, 32'h0000_0020, 16'h0000, 2'b00, 1'b0, got, exp);
    n_checks++;
    if (got.lat !== exp.lat || got.falls !== exp.falls || got.rdata !== 16'h1234) begin
      n_fails++; $display("FAIL reread: got lat %0d falls %0d data %h expected %0d %0d 1234",
                          got.lat, got.falls, got.rdata, exp.lat, exp.falls);
    end
    exec(1'b0, 32'h0000_0020, 16'h0000, 2'b00, 1'b0, got, exp);
    exec(1'b1, 32'h0000_0020, 16'hFFFF, 2'b00, 1'b0, got, exp);
    n_checks++;
    if (got.rdata !== 16'h0000 || got.falls !== 1 || got.lat !== exp.lat) begin
      n_fails++; $display("FAIL read_after_write: got data %h falls %0d lat %0d expected 0000 1 %0d",
                          got.rdata, got.falls, got.lat, exp.lat);
    end
  endtask

  task automatic test_unselected();
    bit any_low;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      ce_falls   = 0;
      any_low    = 1'b0;
      bus_addr   = (c == 0) ? 32'h0100_0020 : 32'h0000_0020;
      bus_iorq_n = (c == 1) ? 1'b0 : 1'b1;
      bus_rd_n   = 1'b0;
      bus_wr_n   = (c == 2) ? 1'b0 : 1'b1;
      bus_req_n  = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (!bus_wait_n) any_low = 1'b1;
      end
      @(posedge clk);
      #1;
      bus_req_n = 1'b1; bus_rd_n = 1'b1; bus_wr_n = 1'b1; bus_iorq_n = 1'b1;
      @(posedge clk);
      n_checks++;
      if (any_low || ce_falls != 0) begin
        n_fails++; $display("FAIL unselected_%0d: got wait_low %b ce_pulses %0d expected 0 0",
                            c, any_low, ce_falls);
      end
    end
  endtask

  task automatic test_random();
    res_t        got, exp;
    bit          is_rd;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      is_rd      = 1'($urandom_range(0, 1));
      a          = 32'($urandom_range(0, 31));
      a[23:19]   = 5'($urandom);
      exec(is_rd, a, 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got, exp);
      n_checks++;
      if (got.lat !== exp.lat || got.falls !== exp.falls) begin
        n_fails++; $display("FAIL rand_timing[%0d]: got lat %0d falls %0d expected lat %0d falls %0d",
                            n, got.lat, got.falls, exp.lat, exp.falls);
      end
      n_checks++;
      if (got.nw !== exp.nw || got.w !== exp.w || got.doe !== exp.doe) begin
        n_fails++; $display("FAIL rand_bus[%0d]: got n=%0d %h oe %b expected n=%0d %h oe %b",
                            n, got.nw, got.w, got.doe, exp.nw, exp.w, exp.doe);
      end
      if (is_rd) begin
        n_checks++;
        if (got.rdata !== exp.rdata) begin
          n_fails++; $display("FAIL rand_rdata[%0d]: got %h expected %h", n, got.rdata, exp.rdata);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1;
    bus_addr = '0; bus_req_n = 1'b1; bus_rd_n = 1'b1; bus_wr_n = 1'b1;
    bus_msk_n = 2'b11; bus_iorq_n = 1'b1; bus_data_in = '0;
    for (int i = 0; i < 8192; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    test_reset();
    test_write_bytes();
    test_partial_write();
    test_read();
    test_cache();
    test_unselected();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
